control: RTL and testbench

Register-file-plus-ALU datapath controller driven by a 12-bit microinstruction each clock. Holds three operand registers (A, B, C) and three result registers (Ao, Bo, Co). Loads operands from two 16-bit memory data buses, performs arithmetic, shift and masking operations, and writes results back. Result registers are exposed as outputs, so a sequencer can build multi-step algorithms such as shift-and-add multiply out of single-cycle opcodes.

---
 rtl/control.sv | 122 ++++++++++++
 tb/tb_control.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/control.sv
// control: three operand registers (A, B, C), three result registers
// (Ao, Bo, Co) and a single-cycle ALU, steered by a 12-bit microinstruction
// sampled on every rising clock edge.
module control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] opcode,
    input  logic [15:0] Mem_Dat_X,
    input  logic [15:0] Mem_Dat_Y,
    output logic [15:0] Aout,
    output logic [15:0] Bout,
    output logic [15:0] Cout
);

    // Function codes
    localparam logic [3:0] FN_ADD  = 4'b0000;
    localparam logic [3:0] FN_SUB  = 4'b0001;
    localparam logic [3:0] FN_AND  = 4'b0010;
    localparam logic [3:0] FN_SHL  = 4'b0011;
    localparam logic [3:0] FN_SHR  = 4'b0100;
    localparam logic [3:0] FN_MASK = 4'b0101;
    localparam logic [3:0] FN_OR   = 4'b0110;
    localparam logic [3:0] FN_XOR  = 4'b0111;
    localparam logic [3:0] FN_NEG  = 4'b1000;
    localparam logic [3:0] FN_LDA  = 4'b1001;
    localparam logic [3:0] FN_SSHR = 4'b1010;
    localparam logic [3:0] FN_LDB  = 4'b1011;
    localparam logic [3:0] FN_LDC  = 4'b1100;

    logic [15:0] r_a, r_b, r_c;
    logic [15:0] r_ao, r_bo, r_co;

    logic        w_mem_cls;   // [11:10]==00: ALU ops and memory loads
    logic [3:0]  w_fn;
    logic [1:0]  w_rsel;
    logic [1:0]  w_dest;
    logic [15:0] w_first;
    logic [15:0] w_rres;      // result register picked by [7:6]
    logic [15:0] w_second;
    logic [15:0] w_alu_res;
    logic        w_alu_vld;
    logic        w_ld_ok;
    logic [15:0] w_ld_val;

    assign w_mem_cls = (opcode[11:10] == 2'b00);
    assign w_fn      = opcode[3:0];
    assign w_rsel    = opcode[7:6];
    assign w_dest    = opcode[5:4];
    assign w_first   = opcode[9] ? r_b : r_a;
    assign w_second  = opcode[8] ? w_rres : r_c;

    // Result-register mux; select 11 reads as zero and never writes on a load
    always_comb begin
        w_rres = 16'h0000;
        case (w_rsel)
            2'b00:   w_rres = r_ao;
            2'b01:   w_rres = r_bo;
            2'b10:   w_rres = r_co;
            default: w_rres = 16'h0000;
        endcase
    end

    // ALU: only active in the memory/ALU class; other codes fall through as no-ops
    always_comb begin
        w_alu_res = 16'h0000;
        w_alu_vld = 1'b0;
        if (w_mem_cls) begin
            w_alu_vld = 1'b1;
            case (w_fn)
                FN_ADD:  w_alu_res = w_first + w_second;
                FN_SUB:  w_alu_res = w_first - w_second;
                FN_AND:  w_alu_res = w_first & w_second;
                FN_SHL:  w_alu_res = {w_first[14:0], 1'b0};
                FN_SHR:  w_alu_res = {1'b0, w_first[15:1]};
                FN_MASK: w_alu_res = w_second[0] ? w_first : 16'h0000;
                FN_OR:   w_alu_res = w_first | w_second;
                FN_XOR:  w_alu_res = w_first ^ w_second;
                FN_NEG:  w_alu_res = (~w_first) + 16'd1;
                FN_SSHR: w_alu_res = {1'b0, w_second[15:1]};
                default: w_alu_vld = 1'b0;
            endcase
        end
    end

    // Load source: memory buses in class 00, otherwise the selected result register
    assign w_ld_ok  = w_mem_cls || (w_rsel != 2'b11);
    assign w_ld_val = w_mem_cls ? ((w_fn == FN_LDC) ? Mem_Dat_Y : Mem_Dat_X) : w_rres;

    // Operand registers: written only by load opcodes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= 16'h0000;
            r_b <= 16'h0000;
            r_c <= 16'h0000;
        end else if (w_ld_ok) begin
            if (w_fn == FN_LDA) r_a <= w_ld_val;
            if (w_fn == FN_LDB) r_b <= w_ld_val;
            if (w_fn == FN_LDC) r_c <= w_ld_val;
        end
    end

    // Result registers: written only by ALU opcodes; destination 11 discards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ao <= 16'h0000;
            r_bo <= 16'h0000;
            r_co <= 16'h0000;
        end else if (w_alu_vld) begin
            case (w_dest)
                2'b00:   r_ao <= w_alu_res;
                2'b01:   r_bo <= w_alu_res;
                2'b10:   r_co <= w_alu_res;
                default: ;
            endcase
        end
    end

    assign Aout = r_ao;
    assign Bout = r_bo;
    assign Cout = r_co;

endmodule

// File: tb/tb_control.sv
// Self-checking bench for control: directed test-plan sequences with fixed
// expected values, then randomized opcodes against a behavioural model.
module tb_control;

    logic        clk;
    logic        rst_n;
    logic [11:0] opcode;
    logic [15:0] mx, my;
    logic [15:0] Aout, Bout, Cout;

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural state: A, B, C, Ao, Bo, Co
    int m_a, m_b, m_c, m_ao, m_bo, m_co;

    control dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .Mem_Dat_X (mx),
        .Mem_Dat_Y (my),
        .Aout      (Aout),
        .Bout      (Bout),
        .Cout      (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    endtask

    task automatic model_clear();
        m_a = 0; m_b = 0; m_c = 0; m_ao = 0; m_bo = 0; m_co = 0;
    endtask

    // Reference: opcode semantics with plain integer arithmetic
    task automatic model_exec(input int op, input int x, input int y);
        int cls, fn, f, s, r, rs, res;
        bit alu;
        cls = (op >> 10) & 3;
        fn  = op & 15;
        rs  = (op >> 6) & 3;
        f   = ((op >> 9) & 1) ? m_b : m_a;
        r   = (rs == 0) ? m_ao : (rs == 1) ? m_bo : (rs == 2) ? m_co : 0;
        s   = ((op >> 8) & 1) ? r : m_c;
        if (fn == 9 || fn == 11 || fn == 12) begin
            if (cls == 0 || rs != 3) begin
                int v;
                v = (cls != 0) ? r : (fn == 12) ? y : x;
                if (fn == 9)  m_a = v;
                if (fn == 11) m_b = v;
                if (fn == 12) m_c = v;
            end
        end else if (cls == 0) begin
            alu = 1;
            res = 0;
            case (fn)
                0:  res = (f + s) % 65536;
                1:  res = (f - s + 65536) % 65536;
                2:  res = f & s;
                3:  res = (f * 2) % 65536;
                4:  res = f / 2;
                5:  res = (s % 2 == 1) ? f : 0;
                6:  res = f | s;
                7:  res = f ^ s;
                8:  res = (65536 - f) % 65536;
                10: res = s / 2;
                default: alu = 0;
            endcase
            if (alu) begin
                case ((op >> 4) & 3)
                    0: m_ao = res;
                    1: m_bo = res;
                    2: m_co = res;
                    default: ;
                endcase
            end
        end
    endtask

    // One instruction: drive at negedge, sample 1ns after the executing edge
    task automatic step(input logic [11:0] op, input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        opcode = op; mx = x; my = y;
        @(posedge clk);
        #1;
        model_exec(int'(op), int'(x), int'(y));
        chk("model_Aout", Aout, 16'(m_ao));
        chk("model_Bout", Bout, 16'(m_bo));
        chk("model_Cout", Cout, 16'(m_co));
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        chk("rst_Aout", Aout, 16'h0000);
        chk("rst_Bout", Bout, 16'h0000);
        chk("rst_Cout", Cout, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [11:0] canon [15] = '{12'h00B, 12'h00C, 12'h200, 12'h000, 12'h208,
                                12'h218, 12'h204, 12'h213, 12'h205, 12'h385,
                                12'h02A, 12'h809, 12'h80B, 12'h84B, 12'h48C};

    initial begin
        opcode = 12'hFFF; mx = 16'h0; my = 16'h0;
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_Aout", Aout, 16'h0000);
        chk("reset_Bout", Bout, 16'h0000);
        chk("reset_Cout", Cout, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Add
        step(12'h00B, 16'h0005, 16'h0003);
        step(12'h00C, 16'h0005, 16'h0003);
        step(12'h200, 16'h0005, 16'h0003);
        chk("add", Aout, 16'h0008);
        // Held opcode
        for (int i = 0; i < 7; i++) begin
            step(12'h200, 16'h0005, 16'h0003);
            chk("hold_add", Aout, 16'h0008);
        end
        // No-ops
        step(12'h00F, 16'h1234, 16'h5678);
        step(12'h800, 16'h1234, 16'h5678);
        step(12'h00D, 16'h1234, 16'h5678);
        chk("nop_Aout", Aout, 16'h0008);
        chk("nop_Bout", Bout, 16'h0000);
        chk("nop_Cout", Cout, 16'h0000);
        // Overflow
        step(12'h00B, 16'hFFFF, 16'h0002);
        step(12'h00C, 16'hFFFF, 16'h0002);
        step(12'h200, 16'hFFFF, 16'h0002);
        chk("add_wrap", Aout, 16'h0001);
        // Two's complement
        step(12'h00B, 16'h0005, 16'h0);
        step(12'h208, 16'h0005, 16'h0);
        chk("neg_5", Aout, 16'hFFFB);
        step(12'h00B, 16'h0000, 16'h0);
        step(12'h208, 16'h0000, 16'h0);
        chk("neg_0", Aout, 16'h0000);
        step(12'h00B, 16'h8000, 16'h0);
        step(12'h208, 16'h8000, 16'h0);
        chk("neg_8000", Aout, 16'h8000);

        // Double shift from clean state
        pulse_reset();
        step(12'h00B, 16'h0014, 16'h0);
        step(12'h204, 16'h0014, 16'h0);
        step(12'h80B, 16'h0014, 16'h0);
        step(12'h204, 16'h0014, 16'h0);
        chk("dshift_Aout", Aout, 16'h0005);
        chk("dshift_Bout", Bout, 16'h0000);
        chk("dshift_Cout", Cout, 16'h0000);

        // Multiply steps
        step(12'h00B, 16'h0005, 16'h0003);
        step(12'h00C, 16'h0005, 16'h0003);
        step(12'h205, 16'h0005, 16'h0003);
        chk("mask", Aout, 16'h0005);
        step(12'h213, 16'h0005, 16'h0003);
        chk("shl_B", Bout, 16'h000A);
        step(12'h02A, 16'h0005, 16'h0003);
        chk("shr_C", Cout, 16'h0001);

        // Full shift-and-add multiply 5*3 over 5 multiplier bits
        pulse_reset();
        step(12'h009, 16'h0000, 16'h0003);
        step(12'h00B, 16'h0005, 16'h0003);
        step(12'h00C, 16'h0005, 16'h0003);
        for (int i = 0; i < 5; i++) begin
            step(12'h225, 16'h0, 16'h0);  // B mask C -> Co
            step(12'h180, 16'h0, 16'h0);  // A + Co -> Ao
            step(12'h809, 16'h0, 16'h0);  // Ao -> A
            step(12'h213, 16'h0, 16'h0);  // B<<1 -> Bo
            step(12'h84B, 16'h0, 16'h0);  // Bo -> B
            step(12'h02A, 16'h0, 16'h0);  // C>>1 -> Co
            step(12'h48C, 16'h0, 16'h0);  // Co -> C
        end
        chk("mult_5x3", Aout, 16'h000F);

        // Reset mid-sequence, then a dependent op sees cleared operands
        step(12'h00B, 16'h1111, 16'h2222);
        step(12'h00C, 16'h1111, 16'h2222);
        step(12'h200, 16'h1111, 16'h2222);
        step(12'h218, 16'h1111, 16'h2222);
        pulse_reset();
        step(12'h200, 16'h1111, 16'h2222);
        chk("post_reset_add", Aout, 16'h0000);

        // Randomized stream against the model
        for (int i = 0; i < 600; i++) begin
            logic [11:0] op;
            if ($urandom_range(0, 99) < 2) pulse_reset();
            if ($urandom_range(0, 1) == 0) op = canon[$urandom_range(0, 14)];
            else op = 12'($urandom_range(0, 4095));
            step(op, 16'($urandom), 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
